// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs : constants shared by fetch, decode and the hazard unit.
//   OPC_HLT        opcode in instr[15:12] that freezes fetch
//   NOP_INSTR      encoding inserted into the pipeline as a bubble
//   ADDR_W/INSTR_W default PC and instruction widths
//   fetch_action_e the single action the fetch stage takes on a given edge
// -----------------------------------------------------------------------------
package cpu_defs;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0]  OPC_HLT   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Ordered by priority: redirect beats stall, stall beats halt, and so on.
  typedef enum logic [2:0] {
    FA_REDIRECT = 3'd0,
    FA_STALL    = 3'd1,
    FA_HALTED   = 3'd2,
    FA_FLUSH    = 3'd3,
    FA_NORMAL   = 3'd4
  } fetch_action_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt : two saturating 32-bit event counters for the fetch stage.
//   clk, rst         clock and synchronous active-high clear
//   fetch_inc        count one valid IF/ID load
//   stall_inc        count one stalled cycle
//   perf_fetch_cnt   number of valid IF/ID loads (saturating)
//   perf_stall_cnt   number of stalled cycles (saturating)
// -----------------------------------------------------------------------------
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  inc;
  logic [31:0] cnt_reg [2];

  assign inc = {stall_inc, fetch_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_fetch_cnt = cnt_reg[0];
  assign perf_stall_cnt = cnt_reg[1];

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage : instruction-fetch stage. Owns the PC and the IF/ID register.
//   clk, rst       clock; synchronous active-high reset
//   stall_if       hold PC, IF/ID and halt state
//   flush_if       load a bubble into IF/ID; PC still advances
//   redirect       load redirect_pc into PC, bubble IF/ID, cancel halt
//   redirect_pc    redirect target
//   im_addr        instruction memory address (current PC)
//   im_rd_en       instruction memory read enable (low once halted)
//   im_instr       word returned by instruction memory for im_addr
//   ifid_instr     IF/ID instruction (NOP when bubble)
//   ifid_pc_plus1  IF/ID PC+1 of the captured instruction
//   ifid_valid     IF/ID holds a real instruction
//   halt_fetched   a HLT has been captured and fetch is frozen
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
// -----------------------------------------------------------------------------
module if_fetch_stage
  import cpu_defs::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                INSTR_W = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_if,
  input  logic               flush_if,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus1,
  output logic               ifid_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic               halt_fetched
);

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(NOP_INSTR);

  logic [ADDR_W-1:0]  pc_reg,         pc_next;
  logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
  logic [ADDR_W-1:0]  ifid_pc1_reg,   ifid_pc1_next;
  logic               ifid_valid_reg, ifid_valid_next;
  logic               halted_reg,     halted_next;

  fetch_action_e      action;
  logic [ADDR_W-1:0]  pc_plus1;
  logic               is_hlt;

  assign pc_plus1 = pc_reg + ADDR_W'(1);   // wraps at 2^ADDR_W
  assign is_hlt   = (im_instr[INSTR_W-1 -: 4] == OPC_HLT);

  always_comb begin
    action = FA_NORMAL;
    if (redirect)        action = FA_REDIRECT;
    else if (stall_if)   action = FA_STALL;
    else if (halted_reg) action = FA_HALTED;
    else if (flush_if)   action = FA_FLUSH;
  end

  always_comb begin
    pc_next         = pc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc1_next   = ifid_pc1_reg;
    ifid_valid_next = ifid_valid_reg;
    halted_next     = halted_reg;
    case (action)
      FA_REDIRECT: begin
        pc_next         = redirect_pc;
        ifid_instr_next = BUBBLE_INSTR;
        ifid_pc1_next   = '0;
        ifid_valid_next = 1'b0;
        halted_next     = 1'b0;        // a wrong-path HLT is cancelled
      end
      FA_STALL: begin
        // everything holds
      end
      FA_HALTED: begin
        ifid_instr_next = BUBBLE_INSTR;
        ifid_pc1_next   = '0;
        ifid_valid_next = 1'b0;
      end
      FA_FLUSH: begin
        // the squashed word is never inspected, so a flushed HLT cannot halt
        pc_next         = pc_plus1;
        ifid_instr_next = BUBBLE_INSTR;
        ifid_pc1_next   = '0;
        ifid_valid_next = 1'b0;
      end
      default: begin
        ifid_instr_next = im_instr;
        ifid_pc1_next   = pc_plus1;
        ifid_valid_next = 1'b1;
        if (is_hlt) begin
          halted_next = 1'b1;          // PC parks on the HLT address
        end else begin
          pc_next = pc_plus1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= RST_PC;
      ifid_instr_reg <= BUBBLE_INSTR;
      ifid_pc1_reg   <= '0;
      ifid_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc1_reg   <= ifid_pc1_next;
      ifid_valid_reg <= ifid_valid_next;
      halted_reg     <= halted_next;
    end
  end

  // Memory-side outputs depend on registered state only.
  assign im_addr       = pc_reg;
  assign im_rd_en      = ~halted_reg;
  assign ifid_instr    = ifid_instr_reg;
  assign ifid_pc_plus1 = ifid_pc1_reg;
  assign ifid_valid    = ifid_valid_reg;
  assign halt_fetched  = halted_reg;

`ifdef IF_PERF_CNT_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = (action == FA_NORMAL);
  assign stall_inc = (action == FA_STALL);

  fetch_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc      (fetch_inc),
    .stall_inc      (stall_inc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage : directed bench for if_fetch_stage with a 64K-word
// instruction memory model that returns mem[im_addr] while clk is low.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        flush_if;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halt_fetched;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  always @(negedge clk) im_instr = mem[im_addr];

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .flush_if      (flush_if),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .im_addr       (im_addr),
    .im_rd_en      (im_rd_en),
    .im_instr      (im_instr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .halt_fetched  (halt_fetched)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc1,
                          input logic vld, input logic [15:0] addr);
    $display("step %s: addr=%h ifid=%h pc1=%h valid=%b halt=%b", tag, im_addr, ifid_instr,
             ifid_pc_plus1, ifid_valid, halt_fetched);
    check({tag, ".instr"}, 32'(ifid_instr), 32'(ins));
    check({tag, ".pc1"},   32'(ifid_pc_plus1), 32'(pc1));
    check({tag, ".valid"}, 32'(ifid_valid), 32'(vld));
    check({tag, ".addr"},  32'(im_addr), 32'(addr));
  endtask

  task automatic chk_bubble(input string tag, input logic [15:0] addr, input logic hlt);
    $display("step %s: addr=%h ifid=%h valid=%b halt=%b rd_en=%b", tag, im_addr, ifid_instr,
             ifid_valid, halt_fetched, im_rd_en);
    check({tag, ".instr"}, 32'(ifid_instr), 32'h0);
    check({tag, ".valid"}, 32'(ifid_valid), 32'h0);
    check({tag, ".addr"},  32'(im_addr), 32'(addr));
    check({tag, ".halt"},  32'(halt_fetched), 32'(hlt));
    check({tag, ".rd_en"}, 32'(im_rd_en), 32'(!hlt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1111;
    mem[16'h0001] = 16'h2222;
    mem[16'h0002] = 16'h3333;
    mem[16'h0003] = 16'hF000;   // HLT that will be flushed
    mem[16'h0004] = 16'h4444;
    mem[16'h0005] = 16'h5555;
    mem[16'h0006] = 16'h6666;
    mem[16'h0007] = 16'hF000;   // real HLT
    mem[16'h0010] = 16'h1010;
    mem[16'h0040] = 16'h4040;
    mem[16'h0041] = 16'h4141;
    mem[16'hFFFF] = 16'h1234;

    rst = 1'b1; stall_if = 1'b0; flush_if = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    tick(); tick();
    chk_bubble("reset", 16'h0000, 1'b0);
    check("reset.pc1", 32'(ifid_pc_plus1), 32'h0);
`ifdef IF_PERF_CNT_EN
    check("reset.perf_fetch", perf_fetch_cnt, 32'd0);
    check("reset.perf_stall", perf_stall_cnt, 32'd0);
`endif

    // Normal fetch: one-cycle latency from address to IF/ID.
    rst = 1'b0;
    tick(); chk_ifid("fetch0", 16'h1111, 16'h0001, 1'b1, 16'h0001);
    tick(); chk_ifid("fetch1", 16'h2222, 16'h0002, 1'b1, 16'h0002);
    tick(); chk_ifid("fetch2", 16'h3333, 16'h0003, 1'b1, 16'h0003);

    // Flush at pc=3 squashes the HLT there; PC still advances.
    flush_if = 1'b1;
    tick(); chk_bubble("flush", 16'h0004, 1'b0);
    flush_if = 1'b0;
    tick(); chk_ifid("fetch4", 16'h4444, 16'h0005, 1'b1, 16'h0005);

    // Stall three cycles at pc=5: everything holds.
    stall_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ifid("stall", 16'h4444, 16'h0005, 1'b1, 16'h0005);
    end
`ifdef IF_PERF_CNT_EN
    check("perf_stall3", perf_stall_cnt, 32'd3);
`endif

    // Redirect wins over a concurrent stall.
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick(); chk_bubble("redir40", 16'h0040, 1'b0);
    redirect = 1'b0; stall_if = 1'b0;
    tick(); chk_ifid("fetch40", 16'h4040, 16'h0041, 1'b1, 16'h0041);
`ifdef IF_PERF_CNT_EN
    check("perf_stall_redir", perf_stall_cnt, 32'd3);
`endif

    // HLT at address 7 freezes fetch.
    redirect = 1'b1; redirect_pc = 16'h0006;
    tick(); chk_bubble("redir6", 16'h0006, 1'b0);
    redirect = 1'b0;
    tick(); chk_ifid("fetch6", 16'h6666, 16'h0007, 1'b1, 16'h0007);
    tick(); chk_ifid("fetch_hlt", 16'hF000, 16'h0008, 1'b1, 16'h0007);
    check("hlt.halt", 32'(halt_fetched), 32'h1);
    check("hlt.rd_en", 32'(im_rd_en), 32'h0);
    tick(); chk_bubble("halted1", 16'h0007, 1'b1);
    tick(); chk_bubble("halted2", 16'h0007, 1'b1);

    // Redirect releases the halt and fetch resumes.
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick(); chk_bubble("redir10", 16'h0010, 1'b0);
    redirect = 1'b0;
    tick(); chk_ifid("fetch10", 16'h1010, 16'h0011, 1'b1, 16'h0011);

    // PC wrap from FFFF to 0000.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick(); chk_bubble("redirFFFF", 16'hFFFF, 1'b0);
    redirect = 1'b0;
    tick(); chk_ifid("fetchFFFF", 16'h1234, 16'h0000, 1'b1, 16'h0000);
    tick(); chk_ifid("fetch_wrap", 16'h1111, 16'h0001, 1'b1, 16'h0001);

`ifdef IF_PERF_CNT_EN
    check("perf_fetch_end", perf_fetch_cnt, 32'd10);
    check("perf_stall_end", perf_stall_cnt, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
